// File: rtl/elevator_car_ctrl.sv
// SCAN-scheduled elevator car: steps floor by floor, sequences the door and
// returns a one-cycle clear pulse for every floor it services.
module elevator_car_ctrl #(
    parameter int NUM_FLOORS        = 8,
    parameter int FLOOR_BITS        = 3,
    parameter int TRAVEL_CYCLES     = 4,
    parameter int DOOR_OPEN_CYCLES  = 6,
    parameter int DOOR_CLOSE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] requests,
    input  logic                  emergency_stop,
    output logic [NUM_FLOORS-1:0] clear_req,
    output logic [FLOOR_BITS-1:0] current_floor,
    output logic [1:0]            door,
    output logic                  up,
    output logic                  down,
    output logic                  idle,
    output logic                  estop
);

    localparam int TMAX_A = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
    localparam int TMAX   = (TMAX_A > DOOR_CLOSE_CYCLES) ? TMAX_A : DOOR_CLOSE_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0]         TRAVEL_LOAD = TW'(TRAVEL_CYCLES);
    localparam logic [TW-1:0]         OPEN_LOAD   = TW'(DOOR_OPEN_CYCLES);
    localparam logic [TW-1:0]         CLOSE_LOAD  = TW'(DOOR_CLOSE_CYCLES);
    localparam logic [TW-1:0]         TIMER_LAST  = TW'(1);
    localparam logic [FLOOR_BITS-1:0] TOP_FLOOR   = FLOOR_BITS'(NUM_FLOORS - 1);

    localparam logic [1:0] DOOR_CLOSED  = 2'b00;
    localparam logic [1:0] DOOR_OPENED  = 2'b01;
    localparam logic [1:0] DOOR_CLOSING = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR_OPEN,
        S_DOOR_CLOSE,
        S_ESTOP
    } state_t;

    state_t                  state_q, state_d;
    state_t                  prior_q, prior_d;
    logic                    dir_up_q, dir_up_d;
    logic [FLOOR_BITS-1:0]   floor_q, floor_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [NUM_FLOORS-1:0]   clear_q, clear_d;
    logic [1:0]              door_q, door_d;
    logic                    up_q, up_d;
    logic                    down_q, down_d;
    logic                    idle_q, idle_d;
    logic                    estop_q, estop_d;

    logic                    here, ahead, behind;
    logic                    at_end, step_dir, here_step, ahead_step;
    logic [FLOOR_BITS-1:0]   step_floor;

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_BITS-1:0] f);
        onehot    = '0;
        onehot[f] = 1'b1;
    endfunction

    function automatic logic pending_beyond(input logic [NUM_FLOORS-1:0] req,
                                            input logic [FLOOR_BITS-1:0] f,
                                            input logic                  toward_up);
        pending_beyond = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req[i] && (toward_up ? (i > int'(f)) : (i < int'(f))))
                pending_beyond = 1'b1;
        end
    endfunction

    assign here   = requests[floor_q];
    assign ahead  = pending_beyond(requests, floor_q, dir_up_q);
    assign behind = pending_beyond(requests, floor_q, ~dir_up_q);

    // A step that would leave the shaft turns the car around in place instead.
    assign at_end     = dir_up_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
    assign step_dir   = at_end ? ~dir_up_q : dir_up_q;
    assign step_floor = at_end ? floor_q : (dir_up_q ? floor_q + 1'b1 : floor_q - 1'b1);
    assign here_step  = requests[step_floor];
    assign ahead_step = pending_beyond(requests, step_floor, step_dir);

    always_comb begin
        state_d  = state_q;
        prior_d  = prior_q;
        dir_up_d = dir_up_q;
        floor_d  = floor_q;
        timer_d  = timer_q;
        clear_d  = '0;

        if (emergency_stop) begin
            state_d = S_ESTOP;
            if (state_q != S_ESTOP)
                prior_d = state_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (here) begin
                        state_d = S_DOOR_OPEN;
                        timer_d = OPEN_LOAD;
                        clear_d = onehot(floor_q);
                    end else if (ahead || behind) begin
                        state_d  = S_MOVE;
                        timer_d  = TRAVEL_LOAD;
                        dir_up_d = ahead ? dir_up_q : ~dir_up_q;
                    end
                end
                S_MOVE: begin
                    if (timer_q == TIMER_LAST) begin
                        floor_d  = step_floor;
                        dir_up_d = step_dir;
                        if (here_step) begin
                            state_d = S_DOOR_OPEN;
                            timer_d = OPEN_LOAD;
                            clear_d = onehot(step_floor);
                        end else if (ahead_step) begin
                            timer_d = TRAVEL_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_DOOR_OPEN: begin
                    // The request that opened the door is still visible during its own clear pulse.
                    if (here && !clear_q[floor_q]) begin
                        timer_d = OPEN_LOAD;
                        clear_d = onehot(floor_q);
                    end else if (timer_q == TIMER_LAST) begin
                        state_d = S_DOOR_CLOSE;
                        timer_d = CLOSE_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_DOOR_CLOSE: begin
                    if (here) begin
                        state_d = S_DOOR_OPEN;
                        timer_d = OPEN_LOAD;
                        clear_d = onehot(floor_q);
                    end else if (timer_q == TIMER_LAST) begin
                        if (ahead || behind) begin
                            state_d  = S_MOVE;
                            timer_d  = TRAVEL_LOAD;
                            dir_up_d = ahead ? dir_up_q : ~dir_up_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                S_ESTOP: begin
                    case (prior_q)
                        S_MOVE: state_d = S_MOVE;
                        S_DOOR_OPEN, S_DOOR_CLOSE: begin
                            state_d = S_DOOR_OPEN;
                            timer_d = OPEN_LOAD;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_DOOR_OPEN:  door_d = DOOR_OPENED;
            S_DOOR_CLOSE: door_d = DOOR_CLOSING;
            S_ESTOP:      door_d = door_q;
            default:      door_d = DOOR_CLOSED;
        endcase
        up_d    = (state_d == S_MOVE) && dir_up_d;
        down_d  = (state_d == S_MOVE) && !dir_up_d;
        idle_d  = (state_d == S_IDLE);
        estop_d = (state_d == S_ESTOP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            prior_q  <= S_IDLE;
            dir_up_q <= 1'b1;
            floor_q  <= '0;
            timer_q  <= '0;
            clear_q  <= '0;
            door_q   <= DOOR_CLOSED;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            idle_q   <= 1'b1;
            estop_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prior_q  <= prior_d;
            dir_up_q <= dir_up_d;
            floor_q  <= floor_d;
            timer_q  <= timer_d;
            clear_q  <= clear_d;
            door_q   <= door_d;
            up_q     <= up_d;
            down_q   <= down_d;
            idle_q   <= idle_d;
            estop_q  <= estop_d;
        end
    end

    assign clear_req     = clear_q;
    assign current_floor = floor_q;
    assign door          = door_q;
    assign up            = up_q;
    assign down          = down_q;
    assign idle          = idle_q;
    assign estop         = estop_q;

endmodule
